tick_timer: RTL and testbench
=============================

TICK_TIMER -- requirements
Module: tick_timer

Interface
REQ-001 Parameter: N, default 8, width of count, load_val and reload register.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-004 tick  input  1  advance enable, one-cycle pulse from the upstream free-running counter's terminal-count output.
REQ-005 start  input  1  one-cycle request to load load_val and begin counting.
REQ-006 stop  input  1  one-cycle abort request.
REQ-007 auto_reload  input  1  selects periodic mode when high.
REQ-008 load_val  input  N  initial and reload count value, sampled only on an accepted start.
REQ-009 count  output  N  current remaining count, driven from a register.
REQ-010 busy  output  1  high while state is RUN.
REQ-011 done  output  1  registered one-cycle pulse at terminal count.

Function
REQ-012 States SHALL be IDLE and RUN; busy SHALL equal (state == RUN).
REQ-013 IDLE, start=1, load_val!=0: next cycle count=load_val, reload_reg=load_val, state=RUN.
REQ-014 IDLE, start=1, load_val==0: next cycle done=1 for one cycle, count=0, state stays IDLE.
REQ-015 IDLE, start=0: count SHALL hold; tick SHALL be ignored.
REQ-016 RUN, tick=1, count>1: count SHALL decrement by exactly 1 at that edge; no done.
REQ-017 RUN, tick=0: count SHALL hold.
REQ-018 RUN, tick=1, count==1, auto_reload=0: next cycle count=0, done=1, state=IDLE.
REQ-019 RUN, tick=1, count==1, auto_reload=1: next cycle count=reload_reg, done=1, state stays RUN.
REQ-020 done SHALL be high in exactly the cycle in which the terminal update of REQ-018 or REQ-019 is first visible on count; it SHALL be low in every other cycle.
REQ-021 RUN, stop=1: next cycle state=IDLE and count holds its current value (tick in the same cycle SHALL be ignored); done SHALL stay low.
REQ-022 Priority per edge SHALL be rst > stop > start > tick.
REQ-023 start while RUN SHALL be ignored (no reload, no restart).
REQ-024 start and stop in the same cycle SHALL behave as stop (IDLE: no effect).
REQ-025 count SHALL never wrap below 0; arithmetic is N-bit unsigned and the decrement is applied only when count>=1.
REQ-026 auto_reload SHALL be sampled only at the terminal-tick edge; changing it mid-period has no other effect.
REQ-027 A period SHALL be exactly load_val tick pulses from the accepted start to done.

Reset
REQ-028 When rst=0 at a rising edge: state=IDLE, count=0, reload_reg=0, busy=0, done=0 in the following cycle.
REQ-029 Reset SHALL override any in-progress count, pending done or simultaneous start/stop/tick.
REQ-030 After rst returns high, the block SHALL accept start on the first subsequent edge.

Structure
REQ-031 Package timer_pkg SHALL hold the state typedef tmr_state_t {IDLE, RUN} and the default width constant TMR_W = 8.
REQ-032 The block SHALL be a single module with no sub-modules; the upstream tick source is instantiated by the integrator, not inside tick_timer.
REQ-033 The state register, count register, reload register and done flop SHALL be separate sequential elements, with next-state logic kept combinational.

Verification
REQ-034 Reset: rst=0 for 2 cycles with start=1, load_val=5 -> count=0, busy=0, done=0 throughout; the start is lost.
REQ-035 One-shot: start, load_val=3, tick every 4th cycle -> count 3,2,1,0; done high one cycle together with count=0; busy falls in the same cycle.
REQ-036 Periodic: auto_reload=1, load_val=2, tick every cycle -> count 2,1,2,1...; done every 2nd cycle; busy stays 1.
REQ-037 Abort: load_val=10, 4 ticks, then stop together with tick -> count holds 6, state IDLE, no done; a further start with load_val=1 plus 1 tick -> done.
REQ-038 Zero load and busy start: start with load_val=0 -> done pulse, busy=0; start with load_val=7 mid-RUN -> ignored, count keeps decrementing from its current value.
REQ-039 Wrap guard: N=4, load_val=15, 15 ticks with auto_reload=0 -> count reaches 0 and never shows 15 again; extra ticks in IDLE -> no change.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the tick-driven countdown timer.
package timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tmr_state_t;

    localparam int unsigned TMR_W = 8;

endpackage

// File: rtl/tick_timer.sv
// Countdown timer advanced by an external tick pulse, with one-shot and
// auto-reload modes and a registered done pulse at terminal count.
module tick_timer
    import timer_pkg::*;
#(
    parameter int unsigned N = TMR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         start,
    input  logic         stop,
    input  logic         auto_reload,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] count,
    output logic         busy,
    output logic         done
);

    localparam logic [N-1:0] ONE = N'(1);

    tmr_state_t   state, state_n;
    logic [N-1:0] count_n;
    logic [N-1:0] reload_reg, reload_n;
    logic         done_n;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!rst) count <= '0;
        else      count <= count_n;
    end

    always_ff @(posedge clk) begin
        if (!rst) reload_reg <= '0;
        else      reload_reg <= reload_n;
    end

    always_ff @(posedge clk) begin
        if (!rst) done <= 1'b0;
        else      done <= done_n;
    end

    // Priority within a cycle is stop > start > tick; start is only honoured in IDLE.
    always_comb begin
        state_n  = state;
        count_n  = count;
        reload_n = reload_reg;
        done_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !stop) begin
                    if (load_val != '0) begin
                        count_n  = load_val;
                        reload_n = load_val;
                        state_n  = RUN;
                    end else begin
                        count_n = '0;
                        done_n  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (tick) begin
                    if (count > ONE) begin
                        count_n = count - ONE;
                    end else if (count == ONE) begin
                        done_n = 1'b1;
                        if (auto_reload) begin
                            count_n = reload_reg;
                        end else begin
                            count_n = '0;
                            state_n = IDLE;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_tick_timer.sv
// Directed self-checking bench for tick_timer (default width and N=4 instance).
module tb_tick_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       start;
    logic       stop;
    logic       auto_reload;
    logic [7:0] load_val8;
    logic [3:0] load_val4;
    logic [7:0] count8;
    logic [3:0] count4;
    logic       busy8, done8, busy4, done4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tick_timer #(.N(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .load_val    (load_val8),
        .count       (count8),
        .busy        (busy8),
        .done        (done8)
    );

    tick_timer #(.N(4)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .load_val    (load_val4),
        .count       (count4),
        .busy        (busy4),
        .done        (done4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle past it before sampling.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string tag, input int c, input int b, input int d);
        check({tag, ".count"}, 32'(count8), 32'(c));
        check({tag, ".busy"},  32'(busy8),  32'(b));
        check({tag, ".done"},  32'(done8),  32'(d));
    endtask

    initial begin
        rst = 1'b0; tick = 1'b0; start = 1'b0; stop = 1'b0; auto_reload = 1'b0;
        load_val8 = '0; load_val4 = '0;
        #1;

        // Reset held two cycles while start is requested: start is lost.
        start = 1'b1; load_val8 = 8'd5; tick = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            check8("reset", 0, 0, 0);
        end
        rst = 1'b1; start = 1'b0; tick = 1'b0;
        cycle();
        check8("reset_lost_start", 0, 0, 0);
        cycle();
        check8("idle_hold", 0, 0, 0);

        // One-shot, load 3, tick every 4th cycle.
        load_val8 = 8'd3; start = 1'b1;
        cycle();
        start = 1'b0;
        check8("oneshot_load", 3, 1, 0);
        for (int k = 2; k >= 0; k--) begin
            for (int j = 0; j < 3; j++) begin
                cycle();
                check8("oneshot_hold", k + 1, 1, 0);
            end
            tick = 1'b1;
            cycle();
            tick = 1'b0;
            check8("oneshot_tick", k, (k != 0) ? 1 : 0, (k == 0) ? 1 : 0);
        end
        cycle();
        check8("oneshot_after", 0, 0, 0);
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        check8("idle_tick_ignored", 0, 0, 0);

        // Periodic, load 2, tick every cycle.
        auto_reload = 1'b1; load_val8 = 8'd2; start = 1'b1;
        cycle();
        start = 1'b0;
        check8("periodic_load", 2, 1, 0);
        tick = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check8("periodic_run", (i % 2 == 0) ? 1 : 2, 1, (i % 2 == 1) ? 1 : 0);
        end
        tick = 1'b0; stop = 1'b1;
        cycle();
        stop = 1'b0; auto_reload = 1'b0;
        check8("periodic_stop", 2, 0, 0);

        // Abort: load 10, 4 ticks, then stop together with tick.
        load_val8 = 8'd10; start = 1'b1;
        cycle();
        start = 1'b0;
        tick = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        check8("abort_4ticks", 6, 1, 0);
        stop = 1'b1;
        cycle();
        stop = 1'b0; tick = 1'b0;
        check8("abort_stop", 6, 0, 0);
        start = 1'b1; stop = 1'b1; load_val8 = 8'd9;
        cycle();
        start = 1'b0; stop = 1'b0;
        check8("start_stop_idle", 6, 0, 0);
        load_val8 = 8'd1; start = 1'b1;
        cycle();
        start = 1'b0;
        check8("abort_restart", 1, 1, 0);
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        check8("abort_done", 0, 0, 1);

        // Zero load gives an immediate done without entering RUN.
        load_val8 = 8'd0; start = 1'b1;
        cycle();
        start = 1'b0;
        check8("zero_load", 0, 0, 1);
        cycle();
        check8("zero_load_after", 0, 0, 0);

        // Start while running is ignored.
        load_val8 = 8'd5; start = 1'b1;
        cycle();
        start = 1'b0;
        tick = 1'b1;
        cycle();
        check8("busy_pre", 4, 1, 0);
        start = 1'b1; load_val8 = 8'd7;
        cycle();
        start = 1'b0;
        check8("busy_start_ignored", 3, 1, 0);
        cycle();
        tick = 1'b0;
        check8("busy_continue", 2, 1, 0);

        // Reset mid-count with start/stop/tick, then start on the first edge after.
        rst = 1'b0; start = 1'b1; stop = 1'b1; tick = 1'b1;
        cycle();
        stop = 1'b0; tick = 1'b0;
        check8("reset_midrun", 0, 0, 0);
        rst = 1'b1; load_val8 = 8'd4; start = 1'b1;
        cycle();
        start = 1'b0;
        check8("post_reset_start", 4, 1, 0);

        // Wrap guard on the 4-bit instance.
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        check("w4_reset.count", 32'(count4), 32'd0);
        load_val4 = 4'd15; load_val8 = 8'd15; start = 1'b1;
        cycle();
        start = 1'b0;
        check("w4_load.count", 32'(count4), 32'd15);
        tick = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            cycle();
            check("w4_run.count", 32'(count4), 32'(15 - i));
            check("w4_run.done", 32'(done4), (i == 15) ? 32'd1 : 32'd0);
        end
        check("w4_end.busy", 32'(busy4), 32'd0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("w4_idle.count", 32'(count4), 32'd0);
            check("w4_idle.busy",  32'(busy4),  32'd0);
            check("w4_idle.done",  32'(done4),  32'd0);
        end
        tick = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
